// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported byte-addressable memory between
// instruction fetch and data load/store. Each granted request takes three cycles
// (IDLE grant, ACC memory strobe, RESP ready pulse). Data wins contention until it
// has taken MAX_STREAK grants in a row while fetch waits, then fetch gets one turn.
// Optional build macro ARB_PERF_CNT_EN adds grant and stall performance counters.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              stall_if,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_fun3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_fun3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_stall_cyc
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_RESP
    } state_t;

    localparam logic [3:0]        STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);
    localparam logic [2:0]        FUN3_WORD  = 3'b010;

    state_t            state;
    state_t            next_state;
    logic              grant_d;
    logic              grant_if;
    logic              d_misaligned;
    logic              mem_access;

    logic              sel_d;
    logic              lat_we;
    logic              lat_mis;
    logic [2:0]        lat_fun3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic [3:0]        streak;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;

    // Halfword accesses need an even address, word accesses a 4-byte aligned one.
    always_comb begin
        d_misaligned = 1'b0;
        case (d_fun3[1:0])
            2'b01:   d_misaligned = d_addr[0];
            2'b10:   d_misaligned = (d_addr[1:0] != 2'b00);
            default: d_misaligned = 1'b0;
        endcase
    end

    // State register; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration in IDLE and the fixed ACC -> RESP -> IDLE sequence.
    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        case (state)
            S_IDLE: begin
                if (d_req && ((streak < STREAK_MAX) || !if_req)) begin
                    grant_d    = 1'b1;
                    next_state = S_ACC;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    next_state = S_ACC;
                end
            end
            S_ACC:   next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Capture the granted request so the requester's fields may change afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_mis   <= 1'b0;
            lat_fun3  <= 3'b000;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
        end else if (grant_d) begin
            sel_d     <= 1'b1;
            lat_we    <= d_we;
            lat_mis   <= d_misaligned;
            lat_fun3  <= d_fun3;
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
        end else if (grant_if) begin
            sel_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_mis   <= 1'b0;
            lat_fun3  <= FUN3_WORD;
            lat_addr  <= if_addr & WORD_MASK;
            lat_wdata <= 32'h0;
        end
    end

    // Count data grants taken while fetch waits; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= 4'd0;
        end else if (state == S_IDLE) begin
            if (grant_if || !if_req) begin
                streak <= 4'd0;
            end else if (grant_d && (streak != STREAK_MAX)) begin
                streak <= streak + 4'd1;
            end
        end
    end

    // Memory strobe in ACC, ready pulses in RESP, read data shown live during the pulse.
    always_comb begin
        mem_access = (state == S_ACC) && !lat_mis;
        mem_en     = mem_access;
        mem_we     = mem_access && lat_we;
        mem_fun3   = mem_access ? lat_fun3 : 3'b000;
        mem_addr   = mem_access ? lat_addr : '0;
        mem_wdata  = mem_access ? lat_wdata : 32'h0;
        if_ready   = (state == S_RESP) && !sel_d;
        d_ready    = (state == S_RESP) && sel_d;
        d_err      = d_ready && lat_mis;
        if_rdata   = if_ready ? mem_rdata : if_rdata_q;
        d_rdata    = d_rdata_q;
        if (d_ready) begin
            if (lat_mis) begin
                d_rdata = 32'h0;
            end else if (!lat_we) begin
                d_rdata = mem_rdata;
            end
        end
        stall_if   = if_req && !if_ready;
    end

    // Hold the last delivered read data between ready pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            if_rdata_q <= if_rdata;
            d_rdata_q  <= d_rdata;
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Free-running grant and fetch-stall counters, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_grants <= 32'h0;
            perf_d_grants  <= 32'h0;
            perf_stall_cyc <= 32'h0;
        end else begin
            if (grant_if) perf_if_grants <= perf_if_grants + 32'd1;
            if (grant_d)  perf_d_grants  <= perf_d_grants + 32'd1;
            if (stall_if) perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model of the arbiter.
module tb_unified_mem_arbiter;

    localparam int AW  = 12;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_ready;
    logic          stall_if;
    logic          d_req;
    logic          d_we;
    logic [2:0]    d_fun3;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_ready;
    logic          d_err;
    logic          mem_en;
    logic          mem_we;
    logic [2:0]    mem_fun3;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   perf_if_grants;
    logic [31:0]   perf_d_grants;
    logic [31:0]   perf_stall_cyc;
`endif

    unified_mem_arbiter #(.ADDR_W(AW), .MAX_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .stall_if(stall_if),
        .d_req(d_req), .d_we(d_we), .d_fun3(d_fun3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_fun3(mem_fun3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
        .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // stimulus controls
    logic        rand_mode = 1'b0;
    logic        hold_mode = 1'b0;
    logic        rand_mem  = 1'b0;
    logic [31:0] mem_fixed = 32'h0;
    logic        got_if = 1'b0;
    logic        got_d  = 1'b0;

    // ready order log (1 = fetch completion)
    logic [15:0] rdy_log = 16'h0;
    int          rdy_n   = 0;

    // reference model state
    int          next_free = 0;
    int          m_streak  = 0;
    logic        t_valid   = 1'b0;
    int          t_acc     = 0;
    logic        t_d, t_we, t_mis;
    logic [2:0]  t_fun3;
    logic [AW-1:0] t_addr;
    logic [31:0] t_wdata;
    logic [31:0] m_if_rdata = 32'h0;
    logic [31:0] m_d_rdata  = 32'h0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
        end
    endtask

    function automatic logic isMisaligned(input logic [2:0] f, input logic [AW-1:0] a);
        case (f)
            3'b001, 3'b101: return (a % 2) != 0;
            3'b010:         return (a % 4) != 0;
            default:        return 1'b0;
        endcase
    endfunction

    task automatic applyStimulus(input int cycles);
        logic [48:0] exp_mem;
        logic        eif, ed, derr, estall, granted;
        logic [2:0]  funs [5];
        funs = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            exp_mem = '0;
            eif = 1'b0; ed = 1'b0; derr = 1'b0; granted = 1'b0;
            if (!rst) begin
                m_if_rdata = 32'h0;
                m_d_rdata  = 32'h0;
                t_valid    = 1'b0;
                m_streak   = 0;
                next_free  = cyc + 1;
            end else if (t_valid) begin
                if (cyc == t_acc && !t_mis)
                    exp_mem = {1'b1, t_d && t_we, t_fun3, t_addr, t_wdata};
                if (cyc == t_acc + 1) begin
                    if (t_d) begin
                        ed = 1'b1;
                        derr = t_mis;
                        if (t_mis) m_d_rdata = 32'h0;
                        else if (!t_we) m_d_rdata = mem_rdata;
                    end else begin
                        eif = 1'b1;
                        m_if_rdata = mem_rdata;
                    end
                    t_valid = 1'b0;
                end
            end
            estall = if_req && !eif;

            checkOutput("mem", {15'h0, mem_en, mem_we, mem_fun3, mem_addr, mem_wdata}, {15'h0, exp_mem});
            checkOutput("ready", {60'h0, if_ready, d_ready, d_err, stall_if}, {60'h0, eif, ed, derr, estall});
            checkOutput("if_rdata", {32'h0, if_rdata}, {32'h0, m_if_rdata});
            checkOutput("d_rdata", {32'h0, d_rdata}, {32'h0, m_d_rdata});

            // arbitration decision when the arbiter is free this cycle
            if (rst && cyc >= next_free) begin
                if (d_req && (m_streak < MAX || !if_req)) begin
                    t_d = 1'b1; t_we = d_we; t_fun3 = d_fun3; t_addr = d_addr;
                    t_wdata = d_wdata; t_mis = isMisaligned(d_fun3, d_addr);
                    m_streak = if_req ? ((m_streak < MAX) ? m_streak + 1 : m_streak) : 0;
                    granted = 1'b1;
                end else if (if_req) begin
                    t_d = 1'b0; t_we = 1'b0; t_fun3 = 3'b010;
                    t_addr = {if_addr[AW-1:2], 2'b00};
                    t_wdata = 32'h0; t_mis = 1'b0;
                    m_streak = 0;
                    granted = 1'b1;
                end else begin
                    m_streak = 0;
                end
                if (granted) begin
                    t_valid = 1'b1;
                    t_acc = cyc + 1;
                    next_free = cyc + 3;
                end else begin
                    next_free = cyc + 1;
                end
            end

            got_if = if_ready;
            got_d  = d_ready;
            if (if_ready || d_ready) begin
                if (rdy_n < 16) rdy_log[rdy_n] = if_ready;
                rdy_n++;
            end

            @(posedge clk);
            #1;
            if (got_if) if_req = 1'b0;
            if (got_d)  d_req  = 1'b0;
            if (rand_mode) begin
                if (!if_req && $urandom_range(0, 1) == 1) begin
                    if_req  = 1'b1;
                    if_addr = AW'($urandom);
                end
                if (!d_req && $urandom_range(0, 2) != 0) begin
                    d_req   = 1'b1;
                    d_we    = 1'($urandom_range(0, 1));
                    d_fun3  = funs[$urandom_range(0, 4)];
                    d_addr  = AW'($urandom);
                    d_wdata = $urandom;
                end
            end
            if (hold_mode) begin
                if_req = 1'b1;
                d_req  = 1'b1;
            end
            mem_rdata = rand_mem ? $urandom : mem_fixed;
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_fun3 = 3'b000; d_addr = '0; d_wdata = 32'h0;
        mem_rdata = 32'h0;
        @(posedge clk);
        #1;
        applyStimulus(3);

        // contention with both requesters held continuously straight out of reset
        rst = 1'b1;
        if_req = 1'b1; if_addr = 12'h100;
        d_req = 1'b1; d_we = 1'b0; d_fun3 = 3'b010; d_addr = 12'h200;
        hold_mode = 1'b1; rand_mem = 1'b1;
        rdy_n = 0; rdy_log = 16'h0;
        applyStimulus(30);
        checkOutput("ready_count", 64'(rdy_n), 64'd10);
        checkOutput("grant_order", {54'h0, rdy_log[9:0]}, 64'h210);
`ifdef ARB_PERF_CNT_EN
        checkOutput("perf_total", 64'(perf_d_grants) + 64'(perf_if_grants), 64'd10);
        checkOutput("perf_if", {32'h0, perf_if_grants}, 64'd2);
        checkOutput("perf_stall", {32'h0, perf_stall_cyc}, 64'd28);
`endif
        hold_mode = 1'b0;
        if_req = 1'b0; d_req = 1'b0;
        applyStimulus(3);

        // fetch only
        rand_mem = 1'b0; mem_fixed = 32'h00500093;
        if_req = 1'b1; if_addr = 12'h010;
        applyStimulus(5);

        // byte store at an odd address
        rand_mem = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_fun3 = 3'b000; d_addr = 12'h003; d_wdata = 32'h000000AB;
        applyStimulus(5);

        // misaligned word load
        d_req = 1'b1; d_we = 1'b0; d_fun3 = 3'b010; d_addr = 12'h006;
        applyStimulus(5);

        // aligned load, then reset while it is in ACC
        d_req = 1'b1; d_we = 1'b0; d_fun3 = 3'b010; d_addr = 12'h040;
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(2);
        rst = 1'b1; d_req = 1'b0;
        if_req = 1'b1; if_addr = 12'h024;
        applyStimulus(5);

        // randomized traffic
        rand_mode = 1'b1;
        applyStimulus(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
